// File: rtl/fp_issue_pkg.sv
// Shared types and defaults for the FP issue/writeback sequencer.
package fp_issue_pkg;

    localparam int unsigned NREGS_DEFAULT           = 32;
    localparam int unsigned MAX_OUTSTANDING_DEFAULT = 4;
    localparam int unsigned REG_AW                  = 5;
    localparam int unsigned TAG_W                   = 6;
    localparam int unsigned CNT_W                   = 4;
    localparam int unsigned RADDR_W                 = 3 * REG_AW;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic              is_fp;
        logic [REG_AW-1:0] rd;
    } fp_tag_t;

    typedef struct packed {
        logic [REG_AW-1:0] rs3;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rd;
        logic              rd_is_fp;
    } issue_req_t;

endpackage

// File: rtl/fp_issue_ctrl_if.sv
// Decoder, FPU and register-file signals of the FP issue controller.
interface fp_issue_ctrl_if;
    import fp_issue_pkg::*;

    logic               instr_valid_i;
    logic               instr_ready_o;
    logic [REG_AW-1:0]  rs1_i;
    logic [REG_AW-1:0]  rs2_i;
    logic [REG_AW-1:0]  rs3_i;
    logic               use_rs1_i;
    logic               use_rs2_i;
    logic               use_rs3_i;
    logic [REG_AW-1:0]  rd_i;
    logic               rd_is_fp_i;
    logic               fpu_in_valid_o;
    logic               fpu_in_ready_i;
    logic [TAG_W-1:0]   fpu_tag_o;
    logic               fpu_out_valid_i;
    logic               fpu_out_ready_o;
    logic [TAG_W-1:0]   fpu_tag_i;
    logic               fpu_flush_o;
    logic               flush_i;
    logic               wb_en_o;
    logic [REG_AW-1:0]  wb_addr_o;
    logic [RADDR_W-1:0] issue_raddr_o;
    logic [CNT_W-1:0]   outstanding_o;
    logic               busy_o;

    modport slave (
        input  instr_valid_i, rs1_i, rs2_i, rs3_i, use_rs1_i, use_rs2_i, use_rs3_i,
               rd_i, rd_is_fp_i, fpu_in_ready_i, fpu_out_valid_i, fpu_tag_i, flush_i,
        output instr_ready_o, fpu_in_valid_o, fpu_tag_o, fpu_out_ready_o, fpu_flush_o,
               wb_en_o, wb_addr_o, issue_raddr_o, outstanding_o, busy_o
    );

    modport master (
        output instr_valid_i, rs1_i, rs2_i, rs3_i, use_rs1_i, use_rs2_i, use_rs3_i,
               rd_i, rd_is_fp_i, fpu_in_ready_i, fpu_out_valid_i, fpu_tag_i, flush_i,
        input  instr_ready_o, fpu_in_valid_o, fpu_tag_o, fpu_out_ready_o, fpu_flush_o,
               wb_en_o, wb_addr_o, issue_raddr_o, outstanding_o, busy_o
    );

endinterface

// File: rtl/fp_scoreboard.sv
// Pending-destination scoreboard: one bit per FP register, set on issue, cleared on writeback.
module fp_scoreboard #(
    parameter int unsigned NREGS = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     set_en_i,
    input  logic [$clog2(NREGS)-1:0] set_idx_i,
    input  logic                     clr_en_i,
    input  logic [$clog2(NREGS)-1:0] clr_idx_i,
    input  logic                     flush_i,
    input  logic [$clog2(NREGS)-1:0] rs1_i,
    input  logic [$clog2(NREGS)-1:0] rs2_i,
    input  logic [$clog2(NREGS)-1:0] rs3_i,
    input  logic [$clog2(NREGS)-1:0] rd_i,
    output logic                     rs1_hit_c,
    output logic                     rs2_hit_c,
    output logic                     rs3_hit_c,
    output logic                     rd_hit_c
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Set and clear never target the same index; flush wipes everything.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) pending_d[clr_idx_i] = 1'b0;
        if (set_en_i) pending_d[set_idx_i] = 1'b1;
        if (flush_i)  pending_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pending_q <= '0;
        else         pending_q <= pending_d;
    end

    assign rs1_hit_c = pending_q[rs1_i];
    assign rs2_hit_c = pending_q[rs2_i];
    assign rs3_hit_c = pending_q[rs3_i];
    assign rd_hit_c  = pending_q[rd_i];

endmodule

// File: rtl/fp_issue_ctrl.sv
// FP issue/writeback sequencer between the FP decoder and fpnew_top.
module fp_issue_ctrl
    import fp_issue_pkg::*;
#(
    parameter int unsigned NREGS           = NREGS_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    fp_issue_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    issue_req_t       req_q, req_d;

    fp_tag_t ret_tag;
    logic    rs1_hit, rs2_hit, rs3_hit, rd_hit;
    logic    hazard, instr_ready, fpu_in_valid;
    logic    accept, issue_hs, retire, wb_en;

    assign ret_tag = fp_tag_t'(bus.fpu_tag_i);

    fp_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .set_en_i  (issue_hs && req_q.rd_is_fp),
        .set_idx_i (req_q.rd),
        .clr_en_i  (wb_en),
        .clr_idx_i (ret_tag.rd),
        .flush_i   (bus.flush_i),
        .rs1_i     (bus.rs1_i),
        .rs2_i     (bus.rs2_i),
        .rs3_i     (bus.rs3_i),
        .rd_i      (bus.rd_i),
        .rs1_hit_c (rs1_hit),
        .rs2_hit_c (rs2_hit),
        .rs3_hit_c (rs3_hit),
        .rd_hit_c  (rd_hit)
    );

    assign hazard = (bus.use_rs1_i && rs1_hit) || (bus.use_rs2_i && rs2_hit) ||
                    (bus.use_rs3_i && rs3_hit) || (bus.rd_is_fp_i && rd_hit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Flush overrides any transition and drops a held op.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (bus.fpu_in_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) state_d = IDLE;
    end

    always_comb begin
        instr_ready  = 1'b0;
        fpu_in_valid = 1'b0;
        case (state_q)
            IDLE:    instr_ready = rst_ni && !bus.flush_i && !hazard &&
                                   (count_q < CNT_W'(MAX_OUTSTANDING));
            ISSUE:   fpu_in_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept   = bus.instr_valid_i && instr_ready;
    assign issue_hs = (state_q == ISSUE) && bus.fpu_in_ready_i && !bus.flush_i;
    assign retire   = rst_ni && bus.fpu_out_valid_i && !bus.flush_i;
    assign wb_en    = retire && ret_tag.is_fp;

    // Outstanding counter: simultaneous issue and retire cancel, saturates at zero.
    always_comb begin
        count_d = count_q;
        if (issue_hs && !retire)                       count_d = count_q + CNT_W'(1);
        else if (!issue_hs && retire && count_q != '0) count_d = count_q - CNT_W'(1);
        if (bus.flush_i) count_d = '0;
    end

    always_comb begin
        req_d = req_q;
        if (accept) begin
            req_d.rs1      = bus.rs1_i;
            req_d.rs2      = bus.rs2_i;
            req_d.rs3      = bus.rs3_i;
            req_d.rd       = bus.rd_i;
            req_d.rd_is_fp = bus.rd_is_fp_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            req_q   <= '0;
        end else begin
            count_q <= count_d;
            req_q   <= req_d;
        end
    end

    assign bus.instr_ready_o   = instr_ready;
    assign bus.fpu_in_valid_o  = fpu_in_valid;
    assign bus.fpu_tag_o       = TAG_W'({req_q.rd_is_fp, req_q.rd});
    assign bus.fpu_out_ready_o = 1'b1;
    assign bus.fpu_flush_o     = bus.flush_i;
    assign bus.wb_en_o         = wb_en;
    assign bus.wb_addr_o       = wb_en ? ret_tag.rd : '0;
    assign bus.issue_raddr_o   = {req_q.rs3, req_q.rs2, req_q.rs1};
    assign bus.outstanding_o   = count_q;
    assign bus.busy_o          = (state_q != IDLE) || (count_q != '0);

    a_no_retire_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(retire && count_q == '0))
        else $error("FPU result returned with no outstanding op");

    a_count_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CNT_W'(MAX_OUTSTANDING))
        else $error("outstanding count above limit");

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Self-checking bench for fp_issue_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_fp_issue_ctrl;

    localparam int MAXO = 4;

    logic clk;
    logic rst_ni;

    fp_issue_ctrl_if ifc ();

    fp_issue_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: pending set, outstanding count, held op, in-flight FPU tags.
    logic [31:0] m_pend;
    int          m_cnt;
    bit          m_have;
    bit          m_fp;
    logic [4:0]  m_rs1, m_rs2, m_rs3, m_rd;
    bit          m_ready;
    logic [5:0]  fq[$];
    int          ret_idx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_cnt = 0; m_have = 0; m_ready = 0;
        m_fp = 0; m_rs1 = '0; m_rs2 = '0; m_rs3 = '0; m_rd = '0;
        fq.delete();
    endtask

    task automatic idle_inputs();
        ifc.instr_valid_i = 1'b0; ifc.rs1_i = '0; ifc.rs2_i = '0; ifc.rs3_i = '0;
        ifc.use_rs1_i = 1'b0; ifc.use_rs2_i = 1'b0; ifc.use_rs3_i = 1'b0;
        ifc.rd_i = '0; ifc.rd_is_fp_i = 1'b0; ifc.fpu_in_ready_i = 1'b0;
        ifc.fpu_out_valid_i = 1'b0; ifc.fpu_tag_i = '0; ifc.flush_i = 1'b0;
    endtask

    task automatic set_instr(input logic [4:0] r1, input bit u1, input logic [4:0] r2, input bit u2,
                             input logic [4:0] rd, input bit fp);
        ifc.instr_valid_i = 1'b1;
        ifc.rs1_i = r1; ifc.use_rs1_i = u1;
        ifc.rs2_i = r2; ifc.use_rs2_i = u2;
        ifc.rs3_i = '0; ifc.use_rs3_i = 1'b0;
        ifc.rd_i = rd;  ifc.rd_is_fp_i = fp;
    endtask

    // Present a returning FPU result for a tag the bench knows is in flight.
    task automatic ret_tag(input logic [5:0] t);
        int found = -1;
        foreach (fq[i]) if (fq[i] == t && found < 0) found = i;
        chk("tb_tag_in_flight", 32'(found >= 0), 32'd1);
        ret_idx = (found < 0) ? 0 : found;
        ifc.fpu_out_valid_i = (found >= 0);
        ifc.fpu_tag_i = t;
    endtask

    task automatic sample();
        bit haz, exp_wb;
        #3;
        if (!rst_ni) return;
        haz = (ifc.use_rs1_i && m_pend[ifc.rs1_i]) || (ifc.use_rs2_i && m_pend[ifc.rs2_i]) ||
              (ifc.use_rs3_i && m_pend[ifc.rs3_i]) || (ifc.rd_is_fp_i && m_pend[ifc.rd_i]);
        m_ready = !m_have && !ifc.flush_i && !haz && (m_cnt < MAXO);
        exp_wb  = ifc.fpu_out_valid_i && !ifc.flush_i && ifc.fpu_tag_i[5];
        chk("instr_ready", 32'(ifc.instr_ready_o), 32'(m_ready));
        chk("fpu_in_valid", 32'(ifc.fpu_in_valid_o), 32'(m_have));
        if (m_have) begin
            chk("fpu_tag", 32'(ifc.fpu_tag_o), 32'({m_fp, m_rd}));
            chk("issue_raddr", 32'(ifc.issue_raddr_o), 32'({m_rs3, m_rs2, m_rs1}));
        end
        chk("wb_en", 32'(ifc.wb_en_o), 32'(exp_wb));
        if (exp_wb) chk("wb_addr", 32'(ifc.wb_addr_o), 32'(ifc.fpu_tag_i[4:0]));
        chk("outstanding", 32'(ifc.outstanding_o), 32'(m_cnt));
        chk("busy", 32'(ifc.busy_o), 32'(m_have || m_cnt != 0));
        chk("fpu_flush", 32'(ifc.fpu_flush_o), 32'(ifc.flush_i));
        chk("fpu_out_ready", 32'(ifc.fpu_out_ready_o), 32'd1);
        chk("pending", dut.u_sb.pending_q, m_pend);
    endtask

    task automatic advance();
        bit hs, ret, acc;
        @(posedge clk);
        if (!rst_ni) begin
            model_reset();
            #1;
            return;
        end
        hs  = m_have && ifc.fpu_in_ready_i && !ifc.flush_i;
        ret = ifc.fpu_out_valid_i && !ifc.flush_i;
        acc = m_ready && ifc.instr_valid_i;
        if (ifc.flush_i) begin
            m_pend = '0; m_cnt = 0; m_have = 0; fq.delete();
        end else begin
            if (ret) begin
                if (ifc.fpu_tag_i[5]) m_pend[ifc.fpu_tag_i[4:0]] = 1'b0;
                fq.delete(ret_idx);
                m_cnt--;
            end
            if (hs) begin
                if (m_fp) m_pend[m_rd] = 1'b1;
                fq.push_back({m_fp, m_rd});
                m_cnt++;
                m_have = 0;
            end
            if (acc) begin
                m_have = 1; m_fp = ifc.rd_is_fp_i; m_rd = ifc.rd_i;
                m_rs1 = ifc.rs1_i; m_rs2 = ifc.rs2_i; m_rs3 = ifc.rs3_i;
            end
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic issue_op(input logic [4:0] rd);
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1);
        ifc.fpu_in_ready_i = 1'b1;
        ifc.fpu_out_valid_i = 1'b0;
        cycle();
        ifc.instr_valid_i = 1'b0;
        cycle();
    endtask

    // Let any held op issue and return every in-flight result, bounded.
    task automatic drain();
        ifc.instr_valid_i = 1'b0; ifc.flush_i = 1'b0; ifc.fpu_in_ready_i = 1'b1;
        for (int i = 0; i < 40 && (m_have || fq.size() > 0); i++) begin
            if (fq.size() > 0) begin
                ret_idx = 0; ifc.fpu_out_valid_i = 1'b1; ifc.fpu_tag_i = fq[0];
            end else begin
                ifc.fpu_out_valid_i = 1'b0;
            end
            cycle();
        end
        ifc.fpu_out_valid_i = 1'b0;
        sample();
        chk("drain_busy", 32'(ifc.busy_o), 32'd0);
        advance();
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst_ni = 1'b0;
        ret_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr_ready", 32'(ifc.instr_ready_o), 32'd0);
        chk("rst_fpu_in_valid", 32'(ifc.fpu_in_valid_o), 32'd0);
        chk("rst_fpu_tag", 32'(ifc.fpu_tag_o), 32'd0);
        chk("rst_out_ready", 32'(ifc.fpu_out_ready_o), 32'd1);
        chk("rst_outstanding", 32'(ifc.outstanding_o), 32'd0);
        chk("rst_busy", 32'(ifc.busy_o), 32'd0);
        chk("rst_raddr", 32'(ifc.issue_raddr_o), 32'd0);
        rst_ni = 1'b1;

        // Basic issue: tag {1,3}, raddr {0,2,1}
        set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
        ifc.fpu_in_ready_i = 1'b1;
        sample(); chk("d1_ready", 32'(ifc.instr_ready_o), 32'd1); advance();
        ifc.instr_valid_i = 1'b0;
        sample();
        chk("d1_in_valid", 32'(ifc.fpu_in_valid_o), 32'd1);
        chk("d1_tag", 32'(ifc.fpu_tag_o), 32'h23);
        chk("d1_raddr", 32'(ifc.issue_raddr_o), 32'h041);
        advance();
        sample();
        chk("d1_outstanding", 32'(ifc.outstanding_o), 32'd1);
        chk("d1_pend3", 32'(dut.u_sb.pending_q[3]), 32'd1);
        advance();

        // RAW stall on f3 until its writeback, released the following cycle
        set_instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
        repeat (3) begin
            sample(); chk("d2_stall", 32'(ifc.instr_ready_o), 32'd0); advance();
        end
        ret_tag(6'h23);
        sample();
        chk("d2_wb_en", 32'(ifc.wb_en_o), 32'd1);
        chk("d2_wb_addr", 32'(ifc.wb_addr_o), 32'd3);
        chk("d2_no_bypass", 32'(ifc.instr_ready_o), 32'd0);
        advance();
        ifc.fpu_out_valid_i = 1'b0;
        sample(); chk("d2_release", 32'(ifc.instr_ready_o), 32'd1); advance();
        drain();

        // Outstanding limit
        for (int r = 4; r <= 7; r++) issue_op(5'(r));
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
        sample();
        chk("d3_full_stall", 32'(ifc.instr_ready_o), 32'd0);
        chk("d3_outstanding", 32'(ifc.outstanding_o), 32'd4);
        advance();
        ret_tag(6'h24);
        sample(); chk("d3_stall_on_ret", 32'(ifc.instr_ready_o), 32'd0); advance();
        ifc.fpu_out_valid_i = 1'b0;
        sample();
        chk("d3_accept", 32'(ifc.instr_ready_o), 32'd1);
        chk("d3_outstanding_3", 32'(ifc.outstanding_o), 32'd3);
        advance();
        drain();

        // FPU backpressure: valid/tag held, count waits for the handshake
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1);
        ifc.fpu_in_ready_i = 1'b0;
        cycle();
        ifc.instr_valid_i = 1'b0;
        repeat (3) begin
            sample();
            chk("d4_valid_held", 32'(ifc.fpu_in_valid_o), 32'd1);
            chk("d4_tag_held", 32'(ifc.fpu_tag_o), 32'h2d);
            chk("d4_no_count", 32'(ifc.outstanding_o), 32'd0);
            advance();
        end
        ifc.fpu_in_ready_i = 1'b1;
        cycle();
        sample(); chk("d4_counted", 32'(ifc.outstanding_o), 32'd1); advance();
        drain();

        // Same-cycle issue (f9) and retirement (f8)
        issue_op(5'd8);
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        ifc.fpu_in_ready_i = 1'b1;
        cycle();
        ifc.instr_valid_i = 1'b0;
        ret_tag(6'h28);
        sample(); chk("d5_in_valid", 32'(ifc.fpu_in_valid_o), 32'd1); advance();
        ifc.fpu_out_valid_i = 1'b0;
        sample();
        chk("d5_outstanding", 32'(ifc.outstanding_o), 32'd1);
        chk("d5_pend9", 32'(dut.u_sb.pending_q[9]), 32'd1);
        chk("d5_pend8", 32'(dut.u_sb.pending_q[8]), 32'd0);
        advance();
        drain();

        // Flush during ISSUE with two outstanding and a returning result
        issue_op(5'd4);
        issue_op(5'd5);
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
        ifc.fpu_in_ready_i = 1'b0;
        cycle();
        ifc.instr_valid_i = 1'b0;
        ifc.flush_i = 1'b1;
        ret_tag(6'h24);
        sample();
        chk("d6_fpu_flush", 32'(ifc.fpu_flush_o), 32'd1);
        chk("d6_wb_en", 32'(ifc.wb_en_o), 32'd0);
        chk("d6_ready", 32'(ifc.instr_ready_o), 32'd0);
        advance();
        ifc.flush_i = 1'b0;
        ifc.fpu_out_valid_i = 1'b0;
        sample();
        chk("d6_outstanding", 32'(ifc.outstanding_o), 32'd0);
        chk("d6_busy", 32'(ifc.busy_o), 32'd0);
        chk("d6_in_valid", 32'(ifc.fpu_in_valid_o), 32'd0);
        chk("d6_pending", dut.u_sb.pending_q, 32'd0);
        advance();

        // Randomized traffic over a small register window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            ifc.instr_valid_i  = 1'($urandom_range(0, 1));
            ifc.rs1_i          = 5'($urandom_range(0, 7));
            ifc.rs2_i          = 5'($urandom_range(0, 7));
            ifc.rs3_i          = 5'($urandom_range(0, 7));
            ifc.use_rs1_i      = 1'($urandom_range(0, 1));
            ifc.use_rs2_i      = 1'($urandom_range(0, 1));
            ifc.use_rs3_i      = 1'($urandom_range(0, 1));
            ifc.rd_i           = 5'($urandom_range(0, 7));
            ifc.rd_is_fp_i     = ($urandom_range(0, 3) != 0);
            ifc.fpu_in_ready_i = ($urandom_range(0, 2) != 0);
            ifc.flush_i        = ($urandom_range(0, 49) == 0);
            if (fq.size() > 0 && $urandom_range(0, 2) == 0) begin
                ret_idx = int'($urandom_range(0, fq.size() - 1));
                ifc.fpu_out_valid_i = 1'b1;
                ifc.fpu_tag_i = fq[ret_idx];
            end else begin
                ifc.fpu_out_valid_i = 1'b0;
                ifc.fpu_tag_i = 6'($urandom);
            end
            cycle();
        end
        drain();

        // Reset with an op held and a result returning: nothing written, all cleared
        issue_op(5'd21);
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1);
        ifc.fpu_in_ready_i = 1'b0;
        cycle();
        ifc.instr_valid_i = 1'b0;
        ret_tag(6'h35);
        rst_ni = 1'b0;
        #3;
        chk("mr_wb_en", 32'(ifc.wb_en_o), 32'd0);
        chk("mr_in_valid", 32'(ifc.fpu_in_valid_o), 32'd0);
        chk("mr_outstanding", 32'(ifc.outstanding_o), 32'd0);
        chk("mr_busy", 32'(ifc.busy_o), 32'd0);
        chk("mr_ready", 32'(ifc.instr_ready_o), 32'd0);
        chk("mr_pending", dut.u_sb.pending_q, 32'd0);
        @(posedge clk);
        model_reset();
        #1;
        idle_inputs();
        rst_ni = 1'b1;
        set_instr(5'd21, 1'b1, 5'd20, 1'b1, 5'd21, 1'b1);
        sample(); chk("mr_accept_after", 32'(ifc.instr_ready_o), 32'd1); advance();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
